fifo_rd_stream_adapter: RTL and testbench
=========================================

// Module: fifo_rd_stream_adapter
//
// PURPOSE
// Read-side stage directly downstream of the synchronous FIFO. Pops words
// whenever the FIFO is non-empty and room exists. Absorbs the FIFO's
// 1-cycle read latency in a 3-entry output buffer. Presents the words as a
// valid/ready stream at full throughput (1 word/clk), with no combinational
// path from m_ready to fifo_rd_en. Also provides a delivered-word counter
// and a synchronous flush.
//
// PARAMETERS
// FIFO_WIDTH  32  data width; must match the FIFO data width
// CNT_WIDTH   16  width of pop_count
//
// PORTS
// clk            in   1           single clock, all logic on posedge
// rst            in   1           asynchronous reset, active-high
// fifo_empty     in   1           FIFO empty flag
// fifo_data_out  in   FIFO_WIDTH  FIFO read data, valid 1 clk after rd_en
// fifo_rd_en     out  1           FIFO pop request
// m_valid        out  1           output word valid
// m_data         out  FIFO_WIDTH  output word (buffer head)
// m_ready        in   1           downstream accepts word
// flush          in   1           synchronous discard of buffered/in-flight data
// pop_count      out  CNT_WIDTH   words delivered (m_valid & m_ready)
// busy           out  1           occ != 0 or inflight == 1
//
// BEHAVIOUR
// - Reset (async, rst=1): occ=0, inflight=0, all buffer entries=0,
//   pop_count=0. Outputs: m_valid=0, m_data=0, fifo_rd_en=0, busy=0.
//   fifo_rd_en is forced 0 while rst is high.
// - State:
//   - occ: 0..3, number of words in the buffer
//   - inflight: set the cycle after fifo_rd_en=1, i.e. data lands now
// - Pop:
//   fifo_rd_en = !rst & !fifo_empty & !flush & (occ + inflight < 3).
//   This is combinational from registers, fifo_empty and flush only.
// - Land: when inflight=1, fifo_data_out is written at the buffer tail.
//   This happens in the same cycle a head pop may occur.
// - Output:
//   - m_valid = (occ != 0); m_data = head entry.
//   - Handshake: m_valid & m_ready in the same clk.
//   - Once m_valid=1, m_data is held stable until the handshake (flush excepted).
// - occ_next = occ + land - handshake. Simultaneous land and handshake keep
//   occ unchanged and preserve FIFO order.
// - Throughput: in steady state occ=1, inflight=1, so the block pops every
//   cycle. Output latency is 2 clk, from fifo_rd_en to m_valid.
// - Boundaries:
//   - occ=3: no pop issued, so the buffer never exceeds 3 entries.
//   - fifo_empty=1: no pop; data already buffered still drains.
//   - Buffer pointers wrap mod 3.
// - pop_count: +1 per handshake, wraps from 2^CNT_WIDTH-1 to 0.
//   Not cleared by flush.
// - flush=1 (sync): next cycle occ=0 and m_valid=0. Any word landing in the
//   flush cycle or the next is discarded (inflight cleared). No pop is issued
//   in the flush cycle. A handshake in the flush cycle still counts.
// - Reset mid-operation: any in-flight word is lost. The FIFO must be reset
//   in the same cycle as this block.
//
// TESTING
// 1. Reset:
//    - Stimulus: rst=1 while fifo_empty=0.
//    - Required: fifo_rd_en=0, m_valid=0, pop_count=0, busy=0.
// 2. Streaming:
//    - Stimulus: FIFO holds 8 words 0x10..0x17, m_ready=1 constantly.
//    - Required: first m_valid 2 clk after first fifo_rd_en. Words appear
//      in order on 8 consecutive cycles. pop_count=8.
// 3. Backpressure:
//    - Stimulus: m_ready=0 with FIFO holding 5 words.
//    - Required: exactly 3 pops, then fifo_rd_en=0. m_data holds 1st word.
//      After m_ready=1, 5 words arrive in order with no loss or duplicate.
// 4. Simultaneous land and pop:
//    - Stimulus: m_ready toggling 1/0 per clk.
//    - Required: occ never exceeds 3, order preserved, pop_count equals the
//      number of handshakes.
// 5. Flush with word in flight:
//    - Stimulus: flush=1 the cycle after fifo_rd_en=1, with occ=2.
//    - Required: next clk m_valid=0, busy=0, and the in-flight word is
//      never presented.
// 6. Counter wrap:
//    - Stimulus: CNT_WIDTH=4, 17 handshakes.
//    - Required: pop_count=1.

Source files
------------

// File: rtl/fifo_rd_stream_adapter_if.sv
// Handshake bundle between the synchronous FIFO read port, the adapter and the
// downstream valid/ready consumer.
interface fifo_rd_stream_adapter_if #(
    parameter int FIFO_WIDTH = 32
);
    logic                  fifo_empty;
    logic [FIFO_WIDTH-1:0] fifo_data_out;
    logic                  fifo_rd_en;
    logic                  m_valid;
    logic [FIFO_WIDTH-1:0] m_data;
    logic                  m_ready;

    modport master (
        input  fifo_empty,
        input  fifo_data_out,
        input  m_ready,
        output fifo_rd_en,
        output m_valid,
        output m_data
    );

    modport slave (
        output fifo_empty,
        output fifo_data_out,
        output m_ready,
        input  fifo_rd_en,
        input  m_valid,
        input  m_data
    );
endinterface

// File: rtl/fifo_rd_stream_adapter.sv
// Pops a 1-cycle-latency FIFO into a 3-entry circular buffer and presents the
// head as a full-rate valid/ready stream, with a delivered-word counter and flush.
module fifo_rd_stream_adapter #(
    parameter int FIFO_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    fifo_rd_stream_adapter_if.master bus,
    input  logic                 flush,
    output logic [CNT_WIDTH-1:0] pop_count,
    output logic                 busy
);
    localparam int DEPTH = 3;

    typedef logic [1:0] ptr_t;

    logic [FIFO_WIDTH-1:0] entries [DEPTH];
    logic [1:0]            occ;
    logic [1:0]            occ_next;
    logic                  inflight;
    ptr_t                  head;
    ptr_t                  tail;
    logic                  land;
    logic                  handshake;
    logic                  rd_en;
    logic                  valid;
    logic [FIFO_WIDTH-1:0] head_data;

    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Pop decision uses only registered state, fifo_empty and flush, never m_ready,
    // so occ + inflight counts every slot that is or will be occupied.
    always_comb begin
        rd_en = 1'b0;
        if (!rst && !bus.fifo_empty && !flush &&
            (({1'b0, occ} + {2'b00, inflight}) < 3'd3)) begin
            rd_en = 1'b1;
        end
    end

    assign valid     = (occ != 2'd0);
    assign head_data = entries[head];
    assign handshake = valid & bus.m_ready;
    assign land      = inflight & ~flush;

    always_comb begin
        occ_next = occ;
        case ({land, handshake})
            2'b10:   occ_next = occ + 2'd1;
            2'b01:   occ_next = occ - 2'd1;
            default: occ_next = occ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ       <= 2'd0;
            inflight  <= 1'b0;
            head      <= 2'd0;
            tail      <= 2'd0;
            pop_count <= '0;
        end else begin
            inflight <= rd_en;
            if (handshake) begin
                pop_count <= pop_count + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end
            if (flush) begin
                occ  <= 2'd0;
                head <= 2'd0;
                tail <= 2'd0;
            end else begin
                occ <= occ_next;
                if (land) begin
                    tail <= ptr_inc(tail);
                end
                if (handshake) begin
                    head <= ptr_inc(head);
                end
            end
        end
    end

    // The tail never aliases the head while a word is held, so landing data
    // cannot disturb the word currently presented.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else if (land) begin
            entries[tail] <= bus.fifo_data_out;
        end
    end

    assign bus.fifo_rd_en = rd_en;
    assign bus.m_valid    = valid;
    assign bus.m_data     = head_data;
    assign busy           = valid | inflight;

`ifndef SYNTHESIS
    a_no_overfill: assert property (@(posedge clk) disable iff (rst)
        (({1'b0, occ} + {2'b00, inflight}) <= 3'd3));

    a_hold_stable: assert property (@(posedge clk) disable iff (rst)
        (valid && !bus.m_ready && !flush) |=> (valid && $stable(head_data)));
`endif

endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// Scoreboard bench for fifo_rd_stream_adapter: a FIFO model feeds the DUT and
// every delivered word is matched against the queue of words expected out.
module tb_fifo_rd_stream_adapter;
    localparam int W  = 32;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic [CW-1:0] pop_count;
    logic          busy;

    fifo_rd_stream_adapter_if #(.FIFO_WIDTH(W)) bus ();

    fifo_rd_stream_adapter #(.FIFO_WIDTH(W), .CNT_WIDTH(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.master),
        .flush     (flush),
        .pop_count (pop_count),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // FIFO model: storage written by the tasks, read pointer owned by this process
    logic [W-1:0] mem [0:255];
    int           wr_idx = 0;
    int           rd_idx = 0;
    logic         fifo_clear = 1'b0;

    assign bus.fifo_empty = (rd_idx == wr_idx);

    always @(posedge clk) begin
        if (fifo_clear) begin
            rd_idx <= wr_idx;
        end else if (bus.fifo_rd_en) begin
            bus.fifo_data_out <= mem[rd_idx[7:0]];
            rd_idx <= rd_idx + 1;
        end
    end

    int            passed = 0;
    int            total  = 0;
    logic [W-1:0]  exp_q [$];
    logic [W-1:0]  exp_w;
    logic [CW-1:0] exp_cnt = '0;

    task automatic load(input logic [W-1:0] w, input bit expect_out);
        mem[wr_idx[7:0]] = w;
        wr_idx++;
        if (expect_out) exp_q.push_back(w);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        flush = 1'b0;
        bus.m_ready = 1'b0;
        load(32'h0000_00AA, 1'b0);
        repeat (2) @(negedge clk);
        total++;
        if (bus.fifo_rd_en !== 1'b0) $display("FAIL reset_rd_en: got %b required 0", bus.fifo_rd_en);
        else passed++;
        total++;
        if (bus.m_valid !== 1'b0) $display("FAIL reset_m_valid: got %b required 0", bus.m_valid);
        else passed++;
        total++;
        if (pop_count !== '0) $display("FAIL reset_pop_count: got %0d required 0", pop_count);
        else passed++;
        total++;
        if (busy !== 1'b0) $display("FAIL reset_busy: got %b required 0", busy);
        else passed++;
        total++;
        if (bus.m_data !== '0) $display("FAIL reset_m_data: got %h required 0", bus.m_data);
        else passed++;
        fifo_clear = 1'b1;
        @(negedge clk);
        fifo_clear = 1'b0;
        rst = 1'b0;
        exp_cnt = '0;
    endtask

    task automatic test_streaming();
        int first_rd = -1;
        int first_vld = -1;
        int first_hs = -1;
        int last_hs = -1;
        int n_hs = 0;
        bus.m_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (c == 0) for (int i = 0; i < 8; i++) load(W'(32'h10 + i), 1'b1);
            #1;
            if (first_rd < 0 && bus.fifo_rd_en) first_rd = c;
            if (first_vld < 0 && bus.m_valid) first_vld = c;
            if (bus.m_valid && bus.m_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    $display("FAIL stream_extra: got %h required no word", bus.m_data);
                end else begin
                    exp_w = exp_q.pop_front();
                    if (bus.m_data !== exp_w) $display("FAIL stream_data: got %h required %h", bus.m_data, exp_w);
                    else passed++;
                end
                exp_cnt = exp_cnt + 1'b1;
                if (first_hs < 0) first_hs = c;
                last_hs = c;
                n_hs++;
            end
        end
        total++;
        if (first_vld - first_rd != 2) $display("FAIL stream_latency: got %0d required 2", first_vld - first_rd);
        else passed++;
        total++;
        if (n_hs != 8 || last_hs - first_hs != 7)
            $display("FAIL stream_consecutive: got %0d words over %0d cycles required 8 over 8", n_hs, last_hs - first_hs + 1);
        else passed++;
        total++;
        if (pop_count !== exp_cnt) $display("FAIL stream_pop_count: got %0d required %0d", pop_count, exp_cnt);
        else passed++;
        total++;
        if (exp_q.size() != 0) $display("FAIL stream_missing: got %0d undelivered required 0", exp_q.size());
        else passed++;
    endtask

    task automatic test_backpressure();
        int n_rd = 0;
        bus.m_ready = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (c == 0) for (int i = 0; i < 5; i++) load(W'(32'h20 + i), 1'b1);
            #1;
            if (bus.fifo_rd_en) n_rd++;
        end
        total++;
        if (n_rd != 3) $display("FAIL bp_pops: got %0d required 3", n_rd);
        else passed++;
        total++;
        if (bus.fifo_rd_en !== 1'b0) $display("FAIL bp_rd_en: got %b required 0", bus.fifo_rd_en);
        else passed++;
        total++;
        if (bus.m_valid !== 1'b1 || bus.m_data !== 32'h20)
            $display("FAIL bp_hold: got valid %b data %h required valid 1 data 00000020", bus.m_valid, bus.m_data);
        else passed++;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            bus.m_ready = 1'b1;
            #1;
            if (bus.m_valid && bus.m_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    $display("FAIL bp_extra: got %h required no word", bus.m_data);
                end else begin
                    exp_w = exp_q.pop_front();
                    if (bus.m_data !== exp_w) $display("FAIL bp_data: got %h required %h", bus.m_data, exp_w);
                    else passed++;
                end
                exp_cnt = exp_cnt + 1'b1;
            end
        end
        total++;
        if (exp_q.size() != 0) $display("FAIL bp_missing: got %0d undelivered required 0", exp_q.size());
        else passed++;
        total++;
        if (pop_count !== exp_cnt) $display("FAIL bp_pop_count: got %0d required %0d", pop_count, exp_cnt);
        else passed++;
    endtask

    task automatic test_land_and_pop();
        int start_rd = rd_idx;
        int dlv = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (c == 0) for (int i = 0; i < 10; i++) load(W'(32'h30 + i), 1'b1);
            total++;
            if (rd_idx - start_rd - dlv > 3 || rd_idx - start_rd - dlv < 0)
                $display("FAIL toggle_outstanding: got %0d required 0..3", rd_idx - start_rd - dlv);
            else passed++;
            bus.m_ready = (c % 2 == 1);
            #1;
            if (bus.m_valid && bus.m_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    $display("FAIL toggle_extra: got %h required no word", bus.m_data);
                end else begin
                    exp_w = exp_q.pop_front();
                    if (bus.m_data !== exp_w) $display("FAIL toggle_data: got %h required %h", bus.m_data, exp_w);
                    else passed++;
                end
                exp_cnt = exp_cnt + 1'b1;
                dlv++;
            end
        end
        total++;
        if (exp_q.size() != 0) $display("FAIL toggle_missing: got %0d undelivered required 0", exp_q.size());
        else passed++;
        total++;
        if (pop_count !== exp_cnt) $display("FAIL toggle_pop_count: got %0d required %0d", pop_count, exp_cnt);
        else passed++;
    endtask

    task automatic test_flush();
        bus.m_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (c == 0) begin
                load(32'h40, 1'b1);
                load(32'h41, 1'b0);
                load(32'h42, 1'b0);
            end
        end
        // third pop was issued last cycle, so two words sit in the buffer and one is landing
        @(negedge clk);
        total++;
        if (bus.m_valid !== 1'b1 || bus.m_data !== 32'h40 || busy !== 1'b1)
            $display("FAIL flush_setup: got valid %b data %h busy %b required 1 00000040 1", bus.m_valid, bus.m_data, busy);
        else passed++;
        flush = 1'b1;
        bus.m_ready = 1'b1;
        #1;
        if (bus.m_valid && bus.m_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                $display("FAIL flush_hs_extra: got %h required no word", bus.m_data);
            end else begin
                exp_w = exp_q.pop_front();
                if (bus.m_data !== exp_w) $display("FAIL flush_hs_data: got %h required %h", bus.m_data, exp_w);
                else passed++;
            end
            exp_cnt = exp_cnt + 1'b1;
        end
        @(negedge clk);
        flush = 1'b0;
        #1;
        total++;
        if (bus.m_valid !== 1'b0) $display("FAIL flush_m_valid: got %b required 0", bus.m_valid);
        else passed++;
        total++;
        if (busy !== 1'b0) $display("FAIL flush_busy: got %b required 0", busy);
        else passed++;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (c == 2) load(32'h50, 1'b1);
            #1;
            if (bus.m_valid && bus.m_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    $display("FAIL flush_extra: got %h required no word", bus.m_data);
                end else begin
                    exp_w = exp_q.pop_front();
                    if (bus.m_data !== exp_w) $display("FAIL flush_data: got %h required %h", bus.m_data, exp_w);
                    else passed++;
                end
                exp_cnt = exp_cnt + 1'b1;
            end
        end
        total++;
        if (exp_q.size() != 0) $display("FAIL flush_missing: got %0d undelivered required 0", exp_q.size());
        else passed++;
        total++;
        if (pop_count !== exp_cnt) $display("FAIL flush_pop_count: got %0d required %0d", pop_count, exp_cnt);
        else passed++;
    endtask

    task automatic test_counter_wrap();
        bus.m_ready = 1'b0;
        rst = 1'b1;
        fifo_clear = 1'b1;
        @(negedge clk);
        fifo_clear = 1'b0;
        total++;
        if (pop_count !== '0) $display("FAIL wrap_reset: got %0d required 0", pop_count);
        else passed++;
        rst = 1'b0;
        exp_cnt = '0;
        exp_q.delete();
        bus.m_ready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (c == 0) for (int i = 0; i < 17; i++) load(W'(32'h60 + i), 1'b1);
            #1;
            if (bus.m_valid && bus.m_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    $display("FAIL wrap_extra: got %h required no word", bus.m_data);
                end else begin
                    exp_w = exp_q.pop_front();
                    if (bus.m_data !== exp_w) $display("FAIL wrap_data: got %h required %h", bus.m_data, exp_w);
                    else passed++;
                end
                exp_cnt = exp_cnt + 1'b1;
            end
        end
        total++;
        if (exp_q.size() != 0) $display("FAIL wrap_missing: got %0d undelivered required 0", exp_q.size());
        else passed++;
        total++;
        if (pop_count !== exp_cnt || pop_count !== 4'd1)
            $display("FAIL wrap_pop_count: got %0d required 1", pop_count);
        else passed++;
    endtask

    initial begin
        bus.m_ready = 1'b0;
        test_reset();
        test_streaming();
        test_backpressure();
        test_land_and_pop();
        test_flush();
        test_counter_wrap();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
